// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_if
//  Description : Symbolic-instruction handshake and instruction-memory write
//                bus for the program-load encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_mnem;
    logic [3:0]        in_rd;
    logic [3:0]        in_rs1;
    logic [3:0]        in_rs2;
    logic [15:0]       in_imm;
    logic              in_last;
    logic              mem_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Producer and instruction-memory side
    modport master (
        output in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm, in_last, mem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    // Encoder side
    modport slave (
        input  in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm, in_last, mem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Encodes symbolic instructions into 32-bit instruction words,
//                buffers them in a FWFT FIFO and writes them to consecutive
//                instruction-memory addresses starting at BASE_ADDR.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    instr_encoder_if.slave   bus,
    output logic             done,
    output logic             err_illegal,
    output logic             busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Encoding shapes: which fields of the word carry operands
    localparam logic [1:0] K_R  = 2'd0;
    localparam logic [1:0] K_I  = 2'd1;
    localparam logic [1:0] K_J  = 2'd2;
    localparam logic [1:0] K_JR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [32:0]       fifo_q [FIFO_DEPTH];   // {last tag, encoded word}
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q;
    logic              pend_q;
    logic              err_q;

    logic [4:0]        w_op;
    logic [2:0]        w_fn;
    logic [1:0]        w_kind;
    logic              w_legal;
    logic [31:0]       w_word;
    logic              w_accept;
    logic              w_push;
    logic              w_write;
    logic              w_empty;
    logic [32:0]       w_head;

    assign w_empty  = (count_q == '0);
    assign w_head   = fifo_q[rptr_q];
    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_push   = w_accept && w_legal;
    // Writes pause for the single DONE cycle so the address counter can rewind
    assign w_write  = !w_empty && bus.mem_ready && (state_q != ST_DONE);

    assign bus.in_ready   = (state_q != ST_DONE) && (count_q < CNT_W'(FIFO_DEPTH));
    assign bus.imem_we    = w_write;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = w_write ? w_head[31:0] : 32'd0;

    assign done        = (state_q == ST_DONE);
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_DONE);
    assign err_illegal = err_q;

    // Mnemonic lookup: opcode, func and operand shape
    always_comb begin
        w_op    = 5'b00000;
        w_fn    = 3'b000;
        w_kind  = K_R;
        w_legal = 1'b1;
        case (bus.in_mnem)
            5'd0, 5'd1, 5'd2,
            5'd3, 5'd4, 5'd5: begin w_op = 5'b00000; w_fn = bus.in_mnem[2:0]; w_kind = K_R; end
            5'd6:  begin w_op = 5'b01000; w_kind = K_I;  end
            5'd7:  begin w_op = 5'b01001; w_kind = K_I;  end
            5'd8:  begin w_op = 5'b00010; w_kind = K_I;  end
            5'd9:  begin w_op = 5'b00011; w_kind = K_I;  end
            5'd10: begin w_op = 5'b00100; w_kind = K_I;  end
            5'd11: begin w_op = 5'b00101; w_kind = K_I;  end
            5'd12: begin w_op = 5'b10000; w_kind = K_J;  end
            5'd13: begin w_op = 5'b00110; w_kind = K_JR; end
            5'd14: begin w_op = 5'b10001; w_kind = K_J;  end
            5'd15: begin w_op = 5'b01010; w_kind = K_I;  end
            5'd16: begin w_op = 5'b01011; w_kind = K_I;  end
            5'd17: begin w_op = 5'b11000; w_fn = 3'b001; w_kind = K_R; end
            5'd18: begin w_op = 5'b11000; w_fn = 3'b010; w_kind = K_R; end
            5'd19: begin w_op = 5'b11000; w_fn = 3'b101; w_kind = K_R; end
            5'd20: begin w_op = 5'b11110; w_kind = K_R;  end
            5'd21: begin w_op = 5'b11011; w_kind = K_I;  end
            5'd22: begin w_op = 5'b11101; w_kind = K_I;  end
            default: w_legal = 1'b0;
        endcase
    end

    // Word assembly from the selected shape; unused fields stay zero
    always_comb begin
        w_word = 32'd0;
        case (w_kind)
            K_R:     w_word = {w_op, w_fn, bus.in_rd, bus.in_rs1, bus.in_rs2, 12'd0};
            K_I:     w_word = {w_op, w_fn, bus.in_rd, bus.in_rs1, bus.in_imm};
            K_J:     w_word = {w_op, w_fn, 8'd0, bus.in_imm};
            default: w_word = {w_op, w_fn, 4'd0, bus.in_rs1, 16'd0};
        endcase
    end

    // FIFO storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wptr_q] <= {bus.in_last, w_word};
        end
    end

    // Occupancy follows push/pop; simultaneous push and pop cancel out
    always_comb begin
        count_d = count_q;
        case ({w_push, w_write})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, address counter, pending-last and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= w_accept && !w_legal;
            if (w_push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (w_write) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (state_q == ST_DONE) begin
                addr_q <= ADDR_W'(BASE_ADDR);
                pend_q <= 1'b0;
            end else begin
                if (w_write) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
                if (w_accept && !w_legal && bus.in_last) begin
                    pend_q <= 1'b1;
                end
            end
        end
    end

    // Program state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Program sequencing: finish on a written last tag or a drained pending-last
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_write && w_head[32]) begin
                    state_d = ST_DONE;
                end else if (w_accept) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if ((w_write && w_head[32]) || (pend_q && w_empty)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Self-checking bench for instr_encoder. A second instance with
//                a 2-bit address shares the stimulus to show counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(10)) u_if ();
    instr_encoder_if #(.ADDR_W(2))  u_if2 ();

    logic mr_man = 1'b1;
    logic mr_rnd = 1'b0;
    logic rnd_en = 1'b0;
    logic done1, err1, busy1, done2, err2, busy2;

    assign u_if.mem_ready  = rnd_en ? mr_rnd : mr_man;
    assign u_if2.mem_ready = u_if.mem_ready;
    assign u_if2.in_valid  = u_if.in_valid;
    assign u_if2.in_mnem   = u_if.in_mnem;
    assign u_if2.in_rd     = u_if.in_rd;
    assign u_if2.in_rs1    = u_if.in_rs1;
    assign u_if2.in_rs2    = u_if.in_rs2;
    assign u_if2.in_imm    = u_if.in_imm;
    assign u_if2.in_last   = u_if.in_last;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .bus(u_if), .done(done1), .err_illegal(err1), .busy(busy1)
    );
    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .bus(u_if2), .done(done2), .err_illegal(err2), .busy(busy2)
    );

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int send_to = 0;
    int prog_idx = 0;

    logic [41:0] obs_q[$];
    logic [33:0] obs2_q[$];
    logic [31:0] exp_w[$];
    int          exp_i[$];

    // Memory-side observer
    always @(negedge clk) begin
        if (u_if.imem_we)  obs_q.push_back({u_if.imem_addr, u_if.imem_wdata});
        if (u_if2.imem_we) obs2_q.push_back({u_if2.imem_addr, u_if2.imem_wdata});
        if (done1) done_cnt++;
        if (err1)  err_cnt++;
    end

    // Random memory back-pressure
    initial forever begin
        @(posedge clk);
        #1 mr_rnd = 1'($urandom_range(0, 1));
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference encoder built from the mnemonic table with plain arithmetic
    function automatic logic [31:0] ref_word(input int m, input int rd, input int rs1,
                                             input int rs2, input int imm);
        int     op, fn, shape;   // shape: 0 R, 1 I, 2 J, 3 rs1-only
        longint w;
        op = 0; fn = 0; shape = 0;
        if (m <= 5) begin
            op = 0; fn = m; shape = 0;
        end else if (m >= 17 && m <= 19) begin
            op = 24; fn = (m == 17) ? 1 : (m == 18) ? 2 : 5; shape = 0;
        end else begin
            case (m)
                6:  begin op = 8;  shape = 1; end
                7:  begin op = 9;  shape = 1; end
                8:  begin op = 2;  shape = 1; end
                9:  begin op = 3;  shape = 1; end
                10: begin op = 4;  shape = 1; end
                11: begin op = 5;  shape = 1; end
                12: begin op = 16; shape = 2; end
                13: begin op = 6;  shape = 3; end
                14: begin op = 17; shape = 2; end
                15: begin op = 10; shape = 1; end
                16: begin op = 11; shape = 1; end
                20: begin op = 30; shape = 0; end
                21: begin op = 27; shape = 1; end
                22: begin op = 29; shape = 1; end
                default: begin op = 0; shape = 0; end
            endcase
        end
        w = longint'(op) * 134217728 + longint'(fn) * 16777216;
        case (shape)
            0: w = w + rd * 1048576 + rs1 * 65536 + rs2 * 4096;
            1: w = w + rd * 1048576 + rs1 * 65536 + imm;
            2: w = w + imm;
            default: w = w + rs1 * 65536;
        endcase
        return w[31:0];
    endfunction

    task automatic send(input int m, input int rd, input int rs1, input int rs2,
                        input int imm, input bit last);
        bit ok;
        ok = 1'b0;
        u_if.in_valid = 1'b1;
        u_if.in_mnem  = 5'(m);
        u_if.in_rd    = 4'(rd);
        u_if.in_rs1   = 4'(rs1);
        u_if.in_rs2   = 4'(rs2);
        u_if.in_imm   = 16'(imm);
        u_if.in_last  = last;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (u_if.in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1 u_if.in_valid = 1'b0;
        if (!ok) send_to++;
        else if (m <= 22) begin
            exp_w.push_back(ref_word(m, rd, rs1, rs2, imm));
            exp_i.push_back(prog_idx);
            prog_idx++;
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        int snap;
        snap = done_cnt;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk); #1;
            if (done_cnt > snap) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_all();
        obs_q.delete(); obs2_q.delete(); exp_w.delete(); exp_i.delete();
        prog_idx = 0;
    endtask

    task automatic test_reset();
        for (int pass = 0; pass < 2; pass++) begin
            n_chk++; if (u_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready pass%0d: got %b expected 1", pass, u_if.in_ready); end
            n_chk++; if (u_if.imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_imem_we pass%0d: got %b expected 0", pass, u_if.imem_we); end
            n_chk++; if (u_if.imem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_imem_addr pass%0d: got %h expected 0", pass, u_if.imem_addr); end
            n_chk++; if (u_if.imem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_imem_wdata pass%0d: got %h expected 0", pass, u_if.imem_wdata); end
            n_chk++; if ({done1, err1, busy1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags pass%0d: got %b expected 000", pass, {done1, err1, busy1}); end
            rst = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_add();
        mr_man = 1'b1;
        clear_all();
        send(0, 1, 2, 3, 0, 1'b1);
        @(negedge clk);
        n_chk++; if ({u_if.imem_we, u_if.imem_addr, u_if.imem_wdata} !== {1'b1, 10'd0, 32'h00123000}) begin
            n_fail++; $display("FAIL add_write: got we=%b addr=%h data=%h expected we=1 addr=0 data=00123000", u_if.imem_we, u_if.imem_addr, u_if.imem_wdata); end
        @(negedge clk);
        n_chk++; if ({done1, u_if.imem_we} !== 2'b10) begin n_fail++; $display("FAIL add_done: got done=%b we=%b expected done=1 we=0", done1, u_if.imem_we); end
        @(negedge clk);
        n_chk++; if ({done1, busy1} !== 2'b00) begin n_fail++; $display("FAIL add_after: got done=%b busy=%b expected 0 0", done1, busy1); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        mr_man = 1'b1;
        clear_all();
        send(6, 4, 5, 0, 16'hBEEF, 1'b0);
        send(18, 6, 7, 8, 0, 1'b1);
        wait_done(50, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_done: got no done expected done"); end
        n_chk++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d writes expected 2", obs_q.size()); end
        else begin
            n_chk++; if (obs_q[0] !== {10'd0, 32'h4045BEEF}) begin n_fail++; $display("FAIL b2b_word0: got %h expected %h", obs_q[0], {10'd0, 32'h4045BEEF}); end
            n_chk++; if (obs_q[1] !== {10'd1, 32'hC2678000}) begin n_fail++; $display("FAIL b2b_word1: got %h expected %h", obs_q[1], {10'd1, 32'hC2678000}); end
        end
    endtask

    task automatic test_backpressure();
        int  acc, idx;
        int  ms[6], rds[6];
        bit  rdy, ok;
        clear_all();
        mr_man = 1'b0;
        for (int i = 0; i < 6; i++) begin ms[i] = i; rds[i] = $urandom_range(0, 15); end
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            idx = (acc < 6) ? acc : 5;
            u_if.in_valid = 1'b1;
            u_if.in_mnem  = 5'(ms[idx]);
            u_if.in_rd    = 4'(rds[idx]);
            u_if.in_rs1   = 4'(idx);
            u_if.in_rs2   = 4'(15 - idx);
            u_if.in_imm   = 16'd0;
            u_if.in_last  = (idx == 3);
            @(negedge clk); rdy = u_if.in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                exp_w.push_back(ref_word(ms[idx], rds[idx], idx, 15 - idx, 0));
                exp_i.push_back(prog_idx); prog_idx++;
                acc++;
            end
        end
        u_if.in_valid = 1'b0;
        n_chk++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
        n_chk++; if (u_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b expected 0", u_if.in_ready); end
        mr_man = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (u_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b expected 1", u_if.in_ready); end
        wait_done(50, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_done: got no done expected done"); end
        n_chk++; if (obs_q.size() !== exp_w.size()) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", obs_q.size(), exp_w.size()); end
        else for (int i = 0; i < obs_q.size(); i++) begin
            n_chk++; if (obs_q[i] !== {10'(exp_i[i]), exp_w[i]}) begin n_fail++; $display("FAIL bp_word%0d: got %h expected %h", i, obs_q[i], {10'(exp_i[i]), exp_w[i]}); end
        end
    endtask

    task automatic test_illegal();
        int  sd, se;
        bit  ok;
        clear_all();
        mr_man = 1'b1;
        sd = done_cnt; se = err_cnt;
        send(25, 1, 1, 1, 1, 1'b1);
        repeat (2) begin @(negedge clk); #1; end
        n_chk++; if (err_cnt - se !== 1) begin n_fail++; $display("FAIL ill_err: got %0d pulses expected 1", err_cnt - se); end
        n_chk++; if (done_cnt - sd !== 1) begin n_fail++; $display("FAIL ill_done: got %0d pulses expected 1", done_cnt - sd); end
        n_chk++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL ill_nowrite: got %0d writes expected 0", obs_q.size()); end
        @(posedge clk); #1;
        clear_all();
        send(1, 9, 10, 11, 0, 1'b1);
        wait_done(50, ok);
        n_chk++; if (!ok || obs_q.size() !== 1) begin n_fail++; $display("FAIL ill_restart: got done=%b writes=%0d expected done=1 writes=1", ok, obs_q.size()); end
        else begin
            n_chk++; if (obs_q[0] !== {10'd0, 32'h019AB000}) begin n_fail++; $display("FAIL ill_restart_word: got %h expected %h", obs_q[0], {10'd0, 32'h019AB000}); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_all();
        mr_man = 1'b1;
        for (int i = 0; i < 5; i++) send(8 + i, i, i + 1, 0, 100 * i + 7, i == 4);
        wait_done(50, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL wrap_done: got no done expected done"); end
        n_chk++; if (obs2_q.size() !== 5 || obs_q.size() !== 5) begin n_fail++; $display("FAIL wrap_count: got %0d/%0d expected 5/5", obs2_q.size(), obs_q.size()); end
        else for (int i = 0; i < 5; i++) begin
            n_chk++; if (obs2_q[i] !== {2'(i % 4), exp_w[i]}) begin n_fail++; $display("FAIL wrap_a2_word%0d: got %h expected %h", i, obs2_q[i], {2'(i % 4), exp_w[i]}); end
            n_chk++; if (obs_q[i] !== {10'(i), exp_w[i]}) begin n_fail++; $display("FAIL wrap_a10_word%0d: got %h expected %h", i, obs_q[i], {10'(i), exp_w[i]}); end
        end
    endtask

    task automatic test_random();
        int  len, m, n_ill, se;
        bit  ok;
        rnd_en = 1'b1;
        for (int p = 0; p < 8; p++) begin
            clear_all();
            len = $urandom_range(1, 8);
            n_ill = 0; se = err_cnt;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 4) == 0) m = $urandom_range(23, 31);
                else m = $urandom_range(0, 22);
                if (m > 22) n_ill++;
                send(m, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 65535), i == len - 1);
            end
            wait_done(300, ok);
            n_chk++; if (!ok) begin n_fail++; $display("FAIL rnd%0d_done: got no done expected done", p); end
            n_chk++; if (err_cnt - se !== n_ill) begin n_fail++; $display("FAIL rnd%0d_err: got %0d expected %0d", p, err_cnt - se, n_ill); end
            n_chk++; if (obs_q.size() !== exp_w.size()) begin n_fail++; $display("FAIL rnd%0d_count: got %0d expected %0d", p, obs_q.size(), exp_w.size()); end
            else for (int i = 0; i < obs_q.size(); i++) begin
                n_chk++; if (obs_q[i] !== {10'(exp_i[i]), exp_w[i]}) begin n_fail++; $display("FAIL rnd%0d_word%0d: got %h expected %h", p, i, obs_q[i], {10'(exp_i[i]), exp_w[i]}); end
            end
        end
        rnd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int sd;
        clear_all();
        mr_man = 1'b0;
        for (int i = 0; i < 3; i++) send(i, i, i, i, 0, 1'b0);
        n_chk++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL rm_busy_before: got %b expected 1", busy1); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if ({u_if.in_ready, u_if.imem_we, done1, err1, busy1} !== 5'b10000) begin n_fail++; $display("FAIL rm_flags: got %b expected 10000", {u_if.in_ready, u_if.imem_we, done1, err1, busy1}); end
        n_chk++; if ({u_if.imem_addr, u_if.imem_wdata} !== 42'd0) begin n_fail++; $display("FAIL rm_bus: got %h expected 0", {u_if.imem_addr, u_if.imem_wdata}); end
        mr_man = 1'b1;
        obs_q.delete();
        sd = done_cnt;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_chk++; if (obs_q.size() !== 0 || done_cnt !== sd) begin n_fail++; $display("FAIL rm_quiet: got writes=%0d done=%0d expected 0 0", obs_q.size(), done_cnt - sd); end
        clear_all();
    endtask

    initial begin
        u_if.in_valid = 1'b0;
        u_if.in_mnem  = 5'd0;
        u_if.in_rd    = 4'd0;
        u_if.in_rs1   = 4'd0;
        u_if.in_rs2   = 4'd0;
        u_if.in_imm   = 16'd0;
        u_if.in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_add();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_wrap();
        test_random();
        test_reset_mid();
        n_chk++; if (send_to !== 0) begin n_fail++; $display("FAIL send_timeouts: got %0d expected 0", send_to); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Program-load path of the interpolation ASIP. Accepts symbolic instructions (mnemonic plus register and immediate fields) over a valid/ready handshake and encodes each into the 32-bit instruction word that the control unit decodes. Buffers the words in a small FIFO and writes them to consecutive instruction-memory addresses. Used by the boot loader and the testbench to fill instruction memory before the core leaves reset.

## Interface
Parameters:
- ADDR_W, 10: instruction-memory word-address width.
- BASE_ADDR, 0: first address written for every program.
- FIFO_DEPTH, 4: encoded-word buffer entries (power of two, ≥2).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has an instruction.
- in_ready  out  1  encoder can accept this cycle.
- in_mnem  in  5  mnemonic id (see Operation).
- in_rd / in_rs1 / in_rs2  in  4 each  register fields.
- in_imm  in  16  immediate / jump target.
- in_last  in  1  final instruction of the program.
- mem_ready  in  1  instruction memory accepts a write this cycle.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded word.
- done  out  1  one-cycle pulse after the last word is written.
- err_illegal  out  1  one-cycle pulse per rejected mnemonic.
- busy  out  1  high in LOAD or DONE.

## Operation
- Word format: [31:27] opcode, [26:24] func, [23:20] rd, [19:16] rs1, [15:0] tail. R-type tail = {rs2, 12'b0}. I/J-type tail = imm. Unused fields are 0.
- Mnemonic map, given as id → opcode/func/type:
  - Scalar ALU ops, opcode 00000, R-type: 0 ADD func 000, 1 SUB 001, 2 MUL 010, 3 SL 011, 4 AND 100, 5 SR 101.
  - 6 ADDI 01000 I; 7 SUBI 01001 I.
  - 8 LW 00010 I; 9 LHW 00011 I; 10 SW 00100 I; 11 SHW 00101 I.
  - 12 JMP 10000 J (rd = rs1 = 0); 13 JR 00110 (rs1 only, tail 0); 14 CALL 10001 J.
  - 15 BE 01010 I; 16 BGT 01011 I.
  - Vector ops, opcode 11000, R-type: 17 VSUB func 001, 18 VMUL 010, 19 VSR 101.
  - 20 VCSUB 11110 R; 21 VLDH 11011 I; 22 VSTB 11101 I.
  - All non-scalar-ALU, non-vector opcodes use func 000.
- Ids 23–31 are illegal:
  - handshake completes, nothing is pushed, err_illegal pulses next cycle;
  - if in_last was set on the illegal id, a pending-last flag is set.
- Accept condition: in_valid && in_ready. in_ready = (state != DONE) && (count < FIFO_DEPTH). There is no same-cycle pop bypass.
- The encoded word plus its last tag are pushed on accept. The FIFO is first-word-fall-through.
- Write condition: FIFO non-empty && mem_ready. On a write:
  - imem_we = 1, imem_wdata = head, imem_addr = address counter;
  - the head is popped and the counter increments.
- Counter wraps from 2^ADDR_W−1 to 0 silently.
- Push and pop in the same cycle leave count unchanged.
- State machine:
  - IDLE → LOAD on first accept.
  - LOAD → DONE when an entry tagged last is written, or when pending-last is set and the FIFO is empty.
  - DONE, one cycle: done = 1, counter = BASE_ADDR, pending-last cleared → IDLE.
- Accepts after a last tag but before DONE are legal and are written after it. They are treated as part of the next program only if DONE has already occurred.

## Timing
- Reset values: in_ready 1, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, done 0, err_illegal 0, busy 0, FIFO empty, state IDLE.
- Latency: word accepted at edge N appears with imem_we = 1 in cycle N+1 (FIFO empty, mem_ready = 1).
- Throughput: one word per cycle sustained.
- imem_we is combinational from FIFO-empty and mem_ready. imem_addr and imem_wdata are stable whenever imem_we = 1.
- With mem_ready low, the FIFO fills. in_ready falls in the cycle count reaches FIFO_DEPTH.
- done is asserted the cycle after the last write. in_ready is 0 during DONE.
- Reset asserted mid-program returns to reset values immediately. The FIFO contents are discarded and no done pulse is generated.

## Test plan
- ADD rd=1 rs1=2 rs2=3, last, mem_ready=1 → imem_we cycle N+1, addr 0, wdata 0x00123000; done next cycle; busy low after.
- ADDI rd=4 rs1=5 imm=0xBEEF then VMUL rd=6 rs1=7 rs2=8, last → addr 0: 0x4045BEEF; addr 1: 0xC2678000; done after second.
- mem_ready=0, offer 6 words → exactly 4 accepted, in_ready low. Release mem_ready → 4 consecutive writes addr 0–3, in_ready high again after first pop.
- Mnemonic 25 with last, FIFO empty → err_illegal pulse, no imem_we, done pulse within 2 cycles; next program restarts at addr 0.
- ADDR_W=2: load 5 words → addresses 0,1,2,3,0 written in order.
- Assert rst while 3 words are buffered → no further imem_we, no done; all outputs at reset values in the same cycle.
